mdu_issue_ctrl: RTL and testbench

Issue/writeback controller that sits directly upstream of the multiplier/divider unit (MDU). It accepts one M-extension request at a time from the execute stage over a valid/ready handshake and registers the operands. It drives the MDU start/operation/operand inputs and holds them stable until the MDU's done pulse. It then returns the result and destination register to writeback over a second valid/ready handshake. It also handles pipeline flush, a watchdog timeout, and optional RISC-V divide corner cases.

---
 rtl/mdu_issue_ctrl.sv | 142 ++++++++++++++
 tb/tb_mdu_issue_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_issue_ctrl.sv
// Issue/writeback controller that hands one M-extension request at a time to the MDU.
// Define MDU_FASTPATH_EN to resolve RISC-V divide corner cases locally, without starting the MDU.
module mdu_issue_ctrl #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int RD_WIDTH       = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [2:0]          req_op,
    input  logic [31:0]         req_x,
    input  logic [31:0]         req_y,
    input  logic [RD_WIDTH-1:0] req_rd,
    input  logic                flush,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [RD_WIDTH-1:0] resp_rd,
    output logic [31:0]         resp_data,
    output logic                resp_err,
    output logic                busy,
    output logic                mdu_start,
    output logic [2:0]          mdu_operation,
    output logic [31:0]         mdu_x,
    output logic [31:0]         mdu_y,
    input  logic                mdu_done,
    input  logic [31:0]         mdu_result
);
    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t                state;
    logic [2:0]            op_q;
    logic [31:0]           x_q;
    logic [31:0]           y_q;
    logic [RD_WIDTH-1:0]   rd_q;
    logic                  kill_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [31:0]           data_q;
    logic                  err_q;
    logic                  accept;
    logic                  timeout;
    logic                  fast_hit;
    logic [31:0]           fast_data;

`ifdef MDU_FASTPATH_EN
    // Returns {hit, result}: divide-by-zero and signed overflow as defined by RISC-V.
    function automatic logic [32:0] div_corner(input logic [2:0]  op,
                                               input logic [31:0] x,
                                               input logic [31:0] y);
        logic signed [31:0] sx;
        logic signed [31:0] sy;
        logic               ovf;
        sx  = x;
        sy  = y;
        ovf = (sx == 32'sh8000_0000) && (sy == -32'sd1);
        div_corner = '0;
        if (op[2]) begin
            if (y == 32'd0)
                div_corner = {1'b1, (op[1] ? x : 32'hFFFF_FFFF)};
            else if (!op[0] && ovf)
                div_corner = {1'b1, (op[1] ? 32'd0 : 32'h8000_0000)};
        end
    endfunction

    assign {fast_hit, fast_data} = div_corner(req_op, req_x, req_y);
`else
    assign fast_hit  = 1'b0;
    assign fast_data = 32'd0;
`endif

    assign accept  = req_valid && req_ready;
    assign timeout = (cnt_q == CNT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            op_q   <= '0;
            x_q    <= '0;
            y_q    <= '0;
            rd_q   <= '0;
            kill_q <= 1'b0;
            cnt_q  <= '0;
            data_q <= '0;
            err_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q   <= req_op;
                        x_q    <= req_x;
                        y_q    <= req_y;
                        rd_q   <= req_rd;
                        kill_q <= 1'b0;
                        if (fast_hit) begin
                            data_q <= fast_data;
                            err_q  <= 1'b0;
                            state  <= RESP;
                        end else begin
                            state  <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    cnt_q <= '0;
                    if (flush) kill_q <= 1'b1;
                    state <= WAIT;
                end
                WAIT: begin
                    // The MDU cannot be aborted, so a killed request still waits for done or timeout.
                    if (mdu_done || timeout) begin
                        data_q <= mdu_done ? mdu_result : 32'd0;
                        err_q  <= !mdu_done;
                        kill_q <= 1'b0;
                        state  <= (kill_q || flush) ? IDLE : RESP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                        if (flush) kill_q <= 1'b1;
                    end
                end
                RESP: begin
                    if (resp_ready || flush) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready     = (state == IDLE) && !flush;
    assign busy          = (state != IDLE);
    assign mdu_start     = (state == ISSUE);
    assign resp_valid    = (state == RESP);
    assign resp_data     = data_q;
    assign resp_err      = err_q;
    assign resp_rd       = rd_q;
    assign mdu_operation = op_q;
    assign mdu_x         = x_q;
    assign mdu_y         = y_q;

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Scoreboard bench for mdu_issue_ctrl with a behavioural MDU stub; expected responses are hand-computed.
module tb_mdu_issue_ctrl;
    localparam int TIMEOUT_CYCLES = 64;
    localparam int RD_WIDTH       = 5;

    typedef struct packed {
        logic [RD_WIDTH-1:0] rd;
        logic [31:0]         data;
        logic                err;
    } exp_t;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                req_valid = 1'b0;
    logic                req_ready;
    logic [2:0]          req_op = '0;
    logic [31:0]         req_x = '0;
    logic [31:0]         req_y = '0;
    logic [RD_WIDTH-1:0] req_rd = '0;
    logic                flush = 1'b0;
    logic                resp_valid;
    logic                resp_ready = 1'b1;
    logic [RD_WIDTH-1:0] resp_rd;
    logic [31:0]         resp_data;
    logic                resp_err;
    logic                busy;
    logic                mdu_start;
    logic [2:0]          mdu_operation;
    logic [31:0]         mdu_x;
    logic [31:0]         mdu_y;
    logic                mdu_done;
    logic [31:0]         mdu_result;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    int   n_pushed = 0;
    int   hs_cnt = 0;
    int   start_cnt = 0;
    exp_t mon_e;

    int unsigned stub_lat = 3;
    logic        stub_hang = 1'b0;
    logic        stub_active;
    int unsigned stub_cnt;

    mdu_issue_ctrl #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .RD_WIDTH(RD_WIDTH)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_x(req_x), .req_y(req_y), .req_rd(req_rd), .flush(flush),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rd(resp_rd),
        .resp_data(resp_data), .resp_err(resp_err), .busy(busy),
        .mdu_start(mdu_start), .mdu_operation(mdu_operation),
        .mdu_x(mdu_x), .mdu_y(mdu_y), .mdu_done(mdu_done), .mdu_result(mdu_result)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    // RISC-V M-extension semantics of the stub MDU
    function automatic logic [31:0] mdu_model(input logic [2:0] op, input logic [31:0] x,
                                              input logic [31:0] y);
        logic signed [31:0] sx;
        logic signed [31:0] sy;
        logic               ovf;
        sx  = x;
        sy  = y;
        ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
        case (op)
            3'b000:  return x * y;
            3'b100:  return (y == 0) ? 32'hFFFF_FFFF : (ovf ? x : 32'(sx / sy));
            3'b101:  return (y == 0) ? 32'hFFFF_FFFF : x / y;
            3'b110:  return (y == 0) ? x : (ovf ? 32'd0 : 32'(sx % sy));
            3'b111:  return (y == 0) ? x : x % y;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mdu_done    <= 1'b0;
            mdu_result  <= '0;
            stub_active <= 1'b0;
            stub_cnt    <= 0;
        end else begin
            mdu_done <= 1'b0;
            if (mdu_start) begin
                stub_active <= !stub_hang;
                stub_cnt    <= 1;
            end else if (stub_active) begin
                if (stub_cnt == stub_lat - 1) begin
                    mdu_done    <= 1'b1;
                    mdu_result  <= mdu_model(mdu_operation, mdu_x, mdu_y);
                    stub_active <= 1'b0;
                end else begin
                    stub_cnt <= stub_cnt + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && mdu_start) start_cnt++;
    end

    // Monitor: compares every completed writeback handshake against the scoreboard
    always @(negedge clk) begin
        #2;
        if (!reset && resp_valid && resp_ready && !flush) begin
            hs_cnt++;
            check("resp_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check("resp_rd", resp_rd, mon_e.rd);
                check("resp_data", resp_data, mon_e.data);
                check("resp_err", resp_err, mon_e.err);
            end
        end
    end

    task automatic expect_resp(input logic [RD_WIDTH-1:0] rd, input logic [31:0] data, input logic err);
        exp_t e;
        e.rd   = rd;
        e.data = data;
        e.err  = err;
        exp_q.push_back(e);
        n_pushed++;
    endtask

    task automatic send(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                        input logic [RD_WIDTH-1:0] rd);
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("req_ready_wait", n < 400, 1);
        req_valid = 1'b1;
        req_op    = op;
        req_x     = x;
        req_y     = y;
        req_rd    = rd;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((busy || exp_q.size() != 0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({name, "_idle_wait"}, n < 400, 1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        int s0;
        int n;

        repeat (3) @(negedge clk);
        check("rst_req_ready", req_ready, 1);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_mdu_start", mdu_start, 0);
        check("rst_mdu_x", mdu_x, 0);
        check("rst_mdu_op", mdu_operation, 0);
        check("rst_resp_data", resp_data, 0);
        check("rst_resp_err", resp_err, 0);
        reset = 1'b0;

        // MUL 7*6: operands must hold until done, exactly one start pulse
        s0 = start_cnt;
        expect_resp(5, 32'd42, 1'b0);
        send(3'b000, 32'd7, 32'd6, 5);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            check("mul_mdu_x", mdu_x, 32'd7);
            check("mul_mdu_y", mdu_y, 32'd6);
            check("mul_mdu_op", mdu_operation, 3'b000);
        end while (!mdu_done && n < 200);
        check("mul_done_seen", mdu_done, 1);
        wait_idle("mul");
        check("mul_start_pulses", start_cnt - s0, 1);

        // DIVU then REMU back-to-back
        expect_resp(1, 32'd14, 1'b0);
        expect_resp(2, 32'd2, 1'b0);
        send(3'b101, 32'd100, 32'd7, 1);
        @(negedge clk);
        check("b2b_req_ready_busy", req_ready, 0);
        check("b2b_busy", busy, 1);
        send(3'b111, 32'd100, 32'd7, 2);
        wait_idle("b2b");

        // Flush in IDLE blocks acceptance
        @(negedge clk);
        flush = 1'b1;
        req_valid = 1'b1;
        req_op = 3'b000; req_x = 32'd1; req_y = 32'd1; req_rd = 1;
        #1 check("idle_flush_req_ready", req_ready, 0);
        @(negedge clk);
        check("idle_flush_not_accepted", busy, 0);
        req_valid = 1'b0;
        flush = 1'b0;
        #1 check("idle_flush_release", req_ready, 1);

        // Backpressure: response held stable for 3 cycles
        resp_ready = 1'b0;
        expect_resp(17, 32'd81, 1'b0);
        send(3'b000, 32'd9, 32'd9, 17);
        n = 0;
        while (!resp_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("hold_resp_seen", resp_valid, 1);
        for (int i = 0; i < 3; i++) begin
            check("hold_resp_valid", resp_valid, 1);
            check("hold_resp_data", resp_data, 32'd81);
            check("hold_resp_rd", resp_rd, 17);
            @(negedge clk);
        end
        resp_ready = 1'b1;
        wait_idle("hold");
        check("hold_released", resp_valid, 0);

        // Flush 5 cycles into WAIT of a DIV: no response, busy until done+1
        stub_lat = 12;
        s0 = start_cnt;
        send(3'b100, 32'd100, 32'd7, 9);
        @(negedge clk);
        check("flush_start", mdu_start, 1);
        repeat (5) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mdu_done && n < 200);
        check("flush_done_seen", mdu_done, 1);
        check("flush_busy_at_done", busy, 1);
        @(negedge clk);
        check("flush_busy_after_done", busy, 0);
        check("flush_no_resp", resp_valid, 0);
        check("flush_start_pulses", start_cnt - s0, 1);
        stub_lat = 3;
        expect_resp(4, 32'd12, 1'b0);
        send(3'b000, 32'd3, 32'd4, 4);
        wait_idle("after_flush");

        // Timeout: MDU never answers
        stub_hang = 1'b1;
        expect_resp(3, 32'd0, 1'b1);
        send(3'b000, 32'd2, 32'd3, 3);
        @(negedge clk);
        check("tmo_start", mdu_start, 1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!resp_valid && n < 200);
        check("tmo_cycles_to_resp", n, TIMEOUT_CYCLES + 1);
        wait_idle("timeout");
        stub_hang = 1'b0;

        // Divide corner cases
        s0 = start_cnt;
        expect_resp(6, 32'hFFFF_FFFF, 1'b0);
        send(3'b100, 32'd5, 32'd0, 6);
        @(negedge clk);
`ifdef MDU_FASTPATH_EN
        check("fast_resp_valid", resp_valid, 1);
`else
        check("div0_issue_start", mdu_start, 1);
`endif
        wait_idle("div0");
        expect_resp(7, 32'h8000_0000, 1'b0);
        send(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 7);
        expect_resp(8, 32'd0, 1'b0);
        send(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 8);
        expect_resp(10, 32'd123, 1'b0);
        send(3'b111, 32'd123, 32'd0, 10);
        wait_idle("corner");
`ifdef MDU_FASTPATH_EN
        check("corner_start_pulses", start_cnt - s0, 0);
`else
        check("corner_start_pulses", start_cnt - s0, 4);
`endif

        repeat (2) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        check("handshake_count", hs_cnt, n_pushed);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
